// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: op codes, FSM state encodings and length limits shared by mem_ctrl.
package mem_ctrl_pkg;
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_COPY  = 2'b10;
   localparam logic [1:0] OP_FILL  = 2'b11;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;
   localparam int ADDR_W_DEF = 4;
   localparam int MAX_LEN = 1 << ADDR_W_DEF;
   function automatic int max_len(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: command-driven LOAD/STORE/COPY/FILL sequencer for a single-port data memory.
// FILL is built only when MEM_CTRL_FILL_EN is defined; otherwise op 11 is rejected with rsp_err.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int LW = ADDR_W + 1;
   localparam logic [ADDR_W:0] LEN_MAX = LW'(max_len(ADDR_W));
   logic [1:0] state, op;
   logic [ADDR_W-1:0] src, dst;
   logic [ADDR_W:0] cnt;
   logic len_bad, len_zero, last;
   assign cmd_ready = state == ST_IDLE && !rst;
   assign busy      = state != ST_IDLE;
   assign rsp_valid = state == ST_RESP;
   assign mem_write = state == ST_WR;
   assign len_bad   = cmd_len > LEN_MAX;
   assign len_zero  = cmd_len == '0;
   assign last      = cnt == LW'(1);
   // src/dst always point at the next address to read/write; mem_wdata doubles as the COPY data register
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= ST_IDLE;
         op        <= OP_LOAD;
         src       <= '0;
         dst       <= '0;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else
         case (state)
            ST_IDLE: if (cmd_valid) begin
               op  <= cmd_op;
               cnt <= LW'(1);
               case (cmd_op)
                  OP_LOAD: begin
                     mem_addr <= cmd_addr;
                     state    <= ST_RD;
                  end
                  OP_STORE: begin
                     mem_addr  <= cmd_addr;
                     mem_wdata <= cmd_wdata;
                     state     <= ST_WR;
                  end
                  OP_COPY:
                     if (len_bad || len_zero) begin
                        rsp_data <= '0;
                        rsp_err  <= len_bad;
                        state    <= ST_RESP;
                     end else begin
                        mem_addr <= cmd_src;
                        src      <= cmd_src + 1'b1;
                        dst      <= cmd_addr;
                        cnt      <= cmd_len;
                        state    <= ST_RD;
                     end
`ifdef MEM_CTRL_FILL_EN
                  default:
                     if (len_bad || len_zero) begin
                        rsp_data <= '0;
                        rsp_err  <= len_bad;
                        state    <= ST_RESP;
                     end else begin
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_wdata;
                        dst       <= cmd_addr + 1'b1;
                        cnt       <= cmd_len;
                        state     <= ST_WR;
                     end
`else
                  default: begin
                     rsp_data <= '0;
                     rsp_err  <= 1'b1;
                     state    <= ST_RESP;
                  end
`endif
               endcase
            end
            ST_RD: begin
               mem_wdata <= mem_rdata;
               if (op == OP_LOAD) begin
                  rsp_data <= mem_rdata;
                  rsp_err  <= 1'b0;
                  state    <= ST_RESP;
               end else begin
                  mem_addr <= dst;
                  dst      <= dst + 1'b1;
                  state    <= ST_WR;
               end
            end
            ST_WR:
               if (last) begin
                  rsp_data <= mem_wdata;
                  rsp_err  <= 1'b0;
                  state    <= ST_RESP;
               end else begin
                  cnt <= cnt - LW'(1);
                  if (op == OP_COPY) begin
                     mem_addr <= src;
                     src      <= src + 1'b1;
                     state    <= ST_RD;
                  end else begin
                     mem_addr <= dst;
                     dst      <= dst + 1'b1;
                  end
               end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Command-driven initiator for the 16×8 single-port data memory. It accepts LOAD, STORE, COPY and FILL commands over a valid/ready handshake and sequences the memory's address, write-data and write-enable lines. It also captures the combinational read data and returns a one-cycle response. It sits between the processor's execute/load-store stage and the data memory instance.

## Interface
- `ADDR_W`, default 4, memory address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 8, memory word width.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: operation code; 00 LOAD, 01 STORE, 10 COPY, 11 FILL.
- `cmd_addr` in ADDR_W: target address (LOAD/STORE) or destination base (COPY/FILL).
- `cmd_src` in ADDR_W: source base for COPY; ignored otherwise.
- `cmd_len` in ADDR_W+1: byte count for COPY/FILL, valid range 0..16; ignored otherwise.
- `cmd_wdata` in DATA_W: store or fill byte.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out DATA_W: result byte.
- `rsp_err` out 1: command rejected; qualified by `rsp_valid`.
- `busy` out 1: a command is in progress.
- `mem_addr` out ADDR_W: to memory `address`.
- `mem_wdata` out DATA_W: to memory `data_in`.
- `mem_write` out 1: to memory `write`.
- `mem_rdata` in DATA_W: from memory `data_out`. Combinational read of `mem_addr`.

## Operation
- **FSM states:** IDLE, RD, WR, RESP.
- **Accept:** a command is accepted when `cmd_valid & cmd_ready`. All fields are latched on accept. `cmd_ready` = 1 only in IDLE and only with `rst` low.
- **LOAD:** IDLE → RD (drive `cmd_addr`, latch `mem_rdata` at the end of the cycle) → RESP. `rsp_data` = byte read.
- **STORE:** IDLE → WR (`mem_write`=1, `mem_wdata`=`cmd_wdata`) → RESP. `rsp_data` = byte written.
- **COPY:** the sequence is (RD src+i, WR dst+i) for i = 0..len-1, ascending, then RESP.
  - The read byte is held in an internal data register and written in the following WR cycle.
  - `rsp_data` = last byte copied.
- **FILL:** len consecutive WR cycles at dst+i with `cmd_wdata`, then RESP. `rsp_data` = `cmd_wdata`.
- **Address arithmetic:** src+i and dst+i wrap modulo 2^ADDR_W. 15+1 → 0.
- **Overlap:** COPY always runs ascending with no overlap correction. When dst is in (src, src+len), re-read bytes propagate; this is defined behaviour.
- **len = 0:** IDLE → RESP with no memory access. `rsp_err`=0, `rsp_data`=0.
- **len > 16:** IDLE → RESP with no memory access. `rsp_err`=1, `rsp_data`=0.
- **Write enable:** `mem_write` is high only in WR. In all other states `mem_addr` holds its last value and `mem_write`=0.
- **Commands during operation:** `cmd_valid` while busy is ignored. The source must hold the command until accepted.
- **Reset:**
  - All outputs reset to 0: `cmd_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `mem_addr`, `mem_wdata`, `mem_write`. State resets to IDLE.
  - Reset mid-command aborts it. Bytes already written stay written, no response is issued, and `mem_write` drops immediately.

## Timing
- Accept at edge N. `busy`=1 from N until RESP exits.
- LOAD and STORE: `rsp_valid` high in cycle N+2. Each cycle counts from the edge that begins it.
- COPY: `rsp_valid` high in cycle N+1+2·len.
- FILL: `rsp_valid` high in cycle N+1+len.
- len = 0 or error: `rsp_valid` high in cycle N+1.
- `rsp_valid` is exactly one cycle, with no backpressure. `rsp_data` and `rsp_err` hold until the next RESP.
- `cmd_ready` returns to 1 the cycle after RESP.
- A STORE write lands at the rising edge ending its WR cycle. A LOAD issued immediately afterwards returns the new value.

## Configuration
- `MEM_CTRL_FILL_EN` defined: FILL (op 11) behaves as described above.
- Not defined: the FILL datapath is omitted. Op 11 is treated as an error: IDLE → RESP, `rsp_err`=1, no memory access.

## Structure
- Shared package `mem_ctrl_pkg` contains:
  - op-code constants `OP_LOAD`, `OP_STORE`, `OP_COPY`, `OP_FILL`;
  - FSM state encodings;
  - `MAX_LEN` = 2^ADDR_W.
- No sub-module. The FSM, byte counter, two address counters and data register fit naturally in one module. The bench instantiates the existing data memory as the responder.

## Test plan
- **STORE/LOAD:** STORE addr 3 data 0xA5, then LOAD addr 3 → `rsp_data`=0xA5, `rsp_err`=0, each rsp 2 cycles after accept.
- **COPY with wrap:** preload 14..15,0 with 0x11,0x22,0x33; COPY src 14 dst 4 len 3 → mem[4..6]=0x11,0x22,0x33, rsp at N+7, `rsp_data`=0x33.
- **FILL:** FILL dst 0 len 16 data 0x5A → all 16 words = 0x5A, rsp at N+17. Without `MEM_CTRL_FILL_EN`: `rsp_err`=1 and memory is unchanged.
- **Edge lengths:** len 0 → rsp at N+1, `rsp_err`=0, no `mem_write`. len 17 → rsp at N+1, `rsp_err`=1, no `mem_write`.
- **Reset mid-operation:** assert `rst` mid-COPY after 2 bytes → `mem_write` drops immediately, no `rsp_valid`, only the first 2 dst bytes are changed, `cmd_ready`=1 one cycle after `rst` deasserts.
- **Overlapping COPY:** src 0 dst 1 len 3 with mem[0]=0x77 → mem[1..3]=0x77.
